// File: rtl/dbuffer_ctrl.sv
// Data-buffer SRAM controller for the MEM stage. It handles byte, half and word loads and stores.
// Sub-word stores are done as read-modify-write because the SRAM has no byte enables.
module dbuffer_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  buffer_csn,
    output logic [ADDR_WIDTH-1:0] buffer_addr,
    output logic                  buffer_write_en,
    output logic                  buffer_read_en,
    output logic [31:0]           buffer_datain,
    input  logic [31:0]           buffer_dataout
);

    typedef enum logic [3:0] {
        IDLE,
        READ,
        READ_WAIT,
        WRITE,
        RMW_RD,
        RMW_MERGE,
        RMW_WR,
        ERR,
        RESP
    } state_t;

    state_t state, state_next;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged_q;

    logic        accept;
    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign buffer_addr = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_next = ERR;
                    else if (!req_we)
                        state_next = READ;
                    else if (req_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = RMW_RD;
                end
            end
            READ:      state_next = READ_WAIT;
            READ_WAIT: state_next = RESP;
            WRITE:     state_next = RESP;
            RMW_RD:    state_next = RMW_MERGE;
            RMW_MERGE: state_next = RMW_WR;
            RMW_WR:    state_next = RESP;
            ERR:       state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The SRAM strobes come only from state and registers. They are forced idle while reset is low.
    always_comb begin
        buffer_csn      = 1'b1;
        buffer_read_en  = 1'b0;
        buffer_write_en = 1'b0;
        buffer_datain   = 32'h0;
        case (state)
            READ, RMW_RD: begin
                buffer_csn     = 1'b0;
                buffer_read_en = 1'b1;
            end
            WRITE: begin
                buffer_csn      = 1'b0;
                buffer_write_en = 1'b1;
                buffer_datain   = wdata_q;
            end
            RMW_WR: begin
                buffer_csn      = 1'b0;
                buffer_write_en = 1'b1;
                buffer_datain   = merged_q;
            end
            default: ;
        endcase
        if (!rst_n) begin
            buffer_csn      = 1'b1;
            buffer_read_en  = 1'b0;
            buffer_write_en = 1'b0;
        end
    end

    always_comb begin
        lane_byte = buffer_dataout[{addr_q[1:0], 3'b000} +: 8];
        lane_half = buffer_dataout[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = unsigned_q ? {16'h0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default: load_ext = buffer_dataout;
        endcase
    end

    always_comb begin
        merged = buffer_dataout;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
            if (state == RMW_MERGE)
                merged_q <= merged;
            // The response registers load on entry to RESP, so they are valid for exactly that one cycle.
            resp_valid <= (state_next == RESP);
            resp_err   <= (state == ERR);
            resp_rdata <= (state == READ_WAIT) ? load_ext : 32'h0;
        end
    end

endmodule

// File: tb/tb_dbuffer_ctrl.sv
// Testbench for dbuffer_ctrl. It uses a behavioural SRAM, a reference memory and a response scoreboard.
// It also checks latency, SRAM strobe behaviour and reset during an RMW access.
module tb_dbuffer_ctrl;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          buffer_csn;
    logic [AW-1:0] buffer_addr;
    logic          buffer_write_en;
    logic          buffer_read_en;
    logic [31:0]   buffer_datain;
    logic [31:0]   buffer_dataout;

    dbuffer_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .buffer_csn      (buffer_csn),
        .buffer_addr     (buffer_addr),
        .buffer_write_en (buffer_write_en),
        .buffer_read_en  (buffer_read_en),
        .buffer_datain   (buffer_datain),
        .buffer_dataout  (buffer_dataout)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] sram    [0:1023];
    logic [31:0] ref_mem [0:1023];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          reads = 0;
    int          writes = 0;
    int          csn_low = 0;
    int          accepts = 0;
    int          issued = 0;
    int          viol = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [31:0]   last_wdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
    end

    // Behavioural SRAM with a registered read port, plus activity counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready)
            accepts <= accepts + 1;
        if (!buffer_csn) begin
            csn_low <= csn_low + 1;
            if (buffer_read_en) begin
                buffer_dataout <= sram[buffer_addr];
                reads <= reads + 1;
            end
            if (buffer_write_en) begin
                sram[buffer_addr] <= buffer_datain;
                writes     <= writes + 1;
                last_waddr <= buffer_addr;
                last_wdata <= buffer_datain;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (buffer_read_en && buffer_write_en)
            viol++;
        if (buffer_csn && (buffer_read_en || buffer_write_en))
            viol++;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
                checkOutput({mon_e.tag, "_err"}, {31'h0, resp_err}, {31'h0, mon_e.err});
                checkOutput({mon_e.tag, "_lat"}, cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
    end

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> (8 * off);
        if (size == 2'b00)
            return uns ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
        if (size == 2'b01)
            return uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
        return word;
    endfunction

    // Drives one request and holds it until it is accepted. The expected response is queued at the accept edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size, input logic uns,
                                 input logic [11:0] addr, input logic [31:0] wdata,
                                 input bit hold, input bit track);
        exp_t        e;
        logic        bad;
        logic [31:0] mask;
        int          n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        issued++;
        if (!hold)
            req_valid = 1'b0;
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e.tag = tag;
        e.acc = cyc;
        e.err = bad;
        e.rdata = 32'h0;
        if (bad)
            e.lat = 2;
        else if (!we) begin
            e.lat = 3;
            e.rdata = modelLoad(ref_mem[addr[11:2]], size, uns, addr[1:0]);
        end else if (size == 2'b10) begin
            e.lat = 2;
            if (track) ref_mem[addr[11:2]] = wdata;
        end else begin
            e.lat = 4;
            mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * addr[1:0]);
            if (track) ref_mem[addr[11:2]] = (ref_mem[addr[11:2]] & ~mask) | ((wdata << (8 * addr[1:0])) & mask);
        end
        if (track)
            sb.push_back(e);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput({tag, "_drain"}, sb.size(), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, r0, c0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        checkOutput("rst_csn", {31'h0, buffer_csn}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        checkOutput("rst_err", {31'h0, resp_err}, 32'd0);

        w0 = writes;
        applyStimulus("st_word", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1);
        waitDrain("st_word");
        checkOutput("st_word_wcount", writes - w0, 32'd1);
        checkOutput("st_word_waddr", {22'h0, last_waddr}, 32'd4);
        checkOutput("st_word_wdata", last_wdata, 32'hDEADBEEF);
        applyStimulus("ld_word", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1);
        waitDrain("ld_word");

        applyStimulus("st_w20", 1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344, 1'b0, 1'b1);
        waitDrain("st_w20");
        w0 = writes;
        r0 = reads;
        applyStimulus("st_byte21", 1'b1, 2'b00, 1'b0, 12'h021, 32'h000000AA, 1'b0, 1'b1);
        waitDrain("st_byte21");
        checkOutput("rmw_reads", reads - r0, 32'd1);
        checkOutput("rmw_writes", writes - w0, 32'd1);
        applyStimulus("st_half22", 1'b1, 2'b01, 1'b0, 12'h022, 32'h000055AA, 1'b0, 1'b1);
        applyStimulus("ld_w20", 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1);
        waitDrain("rmw");
        checkOutput("rmw_final_sram", sram[8], 32'h55AAAA44);

        applyStimulus("st_w30", 1'b1, 2'b10, 1'b0, 12'h030, 32'h80FF7F01, 1'b0, 1'b1);
        applyStimulus("ld_sb31", 1'b0, 2'b00, 1'b0, 12'h031, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld_sb32", 1'b0, 2'b00, 1'b0, 12'h032, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld_uh32", 1'b0, 2'b01, 1'b1, 12'h032, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld_sh32", 1'b0, 2'b01, 1'b0, 12'h032, 32'h0, 1'b0, 1'b1);
        applyStimulus("ld_ub33", 1'b0, 2'b00, 1'b1, 12'h033, 32'h0, 1'b0, 1'b1);
        waitDrain("ext");

        c0 = csn_low;
        applyStimulus("err_word", 1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 1'b0, 1'b1);
        applyStimulus("err_half", 1'b1, 2'b01, 1'b0, 12'h013, 32'hFFFFFFFF, 1'b0, 1'b1);
        applyStimulus("err_size", 1'b1, 2'b11, 1'b0, 12'h010, 32'h12345678, 1'b0, 1'b1);
        waitDrain("err");
        checkOutput("err_csn_cycles", csn_low - c0, 32'd0);
        applyStimulus("ld_after_err", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1);
        waitDrain("ld_after_err");

        r0 = accepts - issued;
        applyStimulus("q_ld0", 1'b0, 2'b10, 1'b0, 12'h030, 32'h0, 1'b1, 1'b1);
        applyStimulus("q_ld1", 1'b0, 2'b00, 1'b1, 12'h030, 32'h0, 1'b1, 1'b1);
        applyStimulus("q_ld2", 1'b0, 2'b01, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1);
        waitDrain("queue");
        checkOutput("queue_accepts", accepts - issued, r0);

        applyStimulus("rst_rmw", 1'b1, 2'b00, 1'b0, 12'h021, 32'h000000CC, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        w0 = writes;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_csn", {31'h0, buffer_csn}, 32'd1);
        checkOutput("rst_mid_wen", {31'h0, buffer_write_en}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_writes", writes - w0, 32'd0);
        checkOutput("rst_mid_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("rst_mid_rvalid", {31'h0, resp_valid}, 32'd0);
        checkOutput("rst_mid_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mid_err", {31'h0, resp_err}, 32'd0);
        applyStimulus("ld_after_rst", 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 1'b0, 1'b1);
        waitDrain("ld_after_rst");

        checkOutput("strobe_protocol", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
